// File: rtl/sound_pkg.sv
// Shared definitions for the Pong sound-effect arbiter: FSM state encoding,
// source indices, counter widths and the fixed-priority helpers.
// Optional feature macro used by the top: SOUND_PREEMPT_EN.
package sound_pkg;

    // Counter widths
    localparam int TONE_W  = 18;
    localparam int DUR_W   = 25;
    localparam int NUM_SRC = 3;

    // Source indices; also the bit positions inside o_grant / pending
    localparam int WALL   = 0;
    localparam int PADDLE = 1;
    localparam int SCORE  = 2;

    // FSM state encoding
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PLAY = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    // One-hot pick of the highest-priority set bit: score > paddle > wall
    function automatic logic [NUM_SRC-1:0] prio_pick(input logic [NUM_SRC-1:0] req);
        logic [NUM_SRC-1:0] pick;
        pick = '0;
        if (req[SCORE])       pick[SCORE]  = 1'b1;
        else if (req[PADDLE]) pick[PADDLE] = 1'b1;
        else if (req[WALL])   pick[WALL]   = 1'b1;
        return pick;
    endfunction

    // Mask of the sources that strictly outrank the given one-hot grant
    function automatic logic [NUM_SRC-1:0] higher_mask(input logic [NUM_SRC-1:0] grant);
        logic [NUM_SRC-1:0] mask;
        mask = '0;
        if (grant[WALL])   mask = 3'b110;
        if (grant[PADDLE]) mask = 3'b100;
        return mask;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Programmable half-period square-wave divider. The tone counter runs
// 0..half-1 and the output toggles on the clock where it reaches half-1.
// load latches a new half-period, clear zeroes counter and output, enable
// lets the counter run. clear takes precedence over enable.
module tone_divider
    import sound_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              enable_i,
    input  logic [TONE_W-1:0] half_i,
    output logic              tone_o
);

    logic [TONE_W-1:0] half_q, half_d;
    logic [TONE_W-1:0] cnt_q,  cnt_d;
    logic              tone_q, tone_d;

    // Next-state: reload, clear, or advance the counter and toggle at wrap
    always_comb begin
        half_d = half_q;
        cnt_d  = cnt_q;
        tone_d = tone_q;
        if (load_i) begin
            half_d = half_i;
        end
        if (clear_i) begin
            cnt_d  = '0;
            tone_d = 1'b0;
        end else if (enable_i) begin
            if (cnt_q == half_q - TONE_W'(1)) begin
                cnt_d  = '0;
                tone_d = ~tone_q;
            end else begin
                cnt_d = cnt_q + TONE_W'(1);
            end
        end
    end

    // Divider state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            half_q <= '0;
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            half_q <= half_d;
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone_o = tone_q;

endmodule

// File: rtl/sound_effect_arbiter.sv
// Pong sound-effect arbiter: latches one-cycle requests, grants one effect at
// a time by fixed priority (score > paddle > wall), plays its tone for the
// effect duration and then holds a silent gap before the next grant.
// Optional feature: define SOUND_PREEMPT_EN to let a strictly higher-priority
// pending effect cut in during PLAY (the interrupted effect is dropped).
module sound_effect_arbiter
    import sound_pkg::*;
#(
    parameter int unsigned HALF_PADDLE = 113_636,
    parameter int unsigned HALF_WALL   = 227_272,
    parameter int unsigned HALF_SCORE  = 56_818,
    parameter int unsigned DUR_PADDLE  = 5_000_000,
    parameter int unsigned DUR_WALL    = 5_000_000,
    parameter int unsigned DUR_SCORE   = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 1_000_000
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       i_req_paddle,
    input  logic       i_req_wall,
    input  logic       i_req_score,
    output logic       o_speaker,
    output logic       o_busy,
    output logic [2:0] o_grant
);

    logic [1:0]         state_q,   state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] grant_q,   grant_d;
    logic               busy_q,    busy_d;
    logic [DUR_W-1:0]   cnt_q,     cnt_d;

    logic [NUM_SRC-1:0] req_vec;
    logic [NUM_SRC-1:0] pick;
    logic [NUM_SRC-1:0] grant_clr;
    logic               preempt;
    logic               div_load;
    logic               div_clear;
    logic               div_en;
    logic [TONE_W-1:0]  div_half;

    // Per-effect tone half-period
    function automatic logic [TONE_W-1:0] half_of(input logic [NUM_SRC-1:0] g);
        if (g[SCORE])       return TONE_W'(HALF_SCORE);
        else if (g[PADDLE]) return TONE_W'(HALF_PADDLE);
        else                return TONE_W'(HALF_WALL);
    endfunction

    // Per-effect play length
    function automatic logic [DUR_W-1:0] dur_of(input logic [NUM_SRC-1:0] g);
        if (g[SCORE])       return DUR_W'(DUR_SCORE);
        else if (g[PADDLE]) return DUR_W'(DUR_PADDLE);
        else                return DUR_W'(DUR_WALL);
    endfunction

    assign req_vec = {i_req_score, i_req_paddle, i_req_wall};
    assign pick    = prio_pick(pending_q);

    // Sticky pending bits; a request landing on the grant edge of the same
    // source is absorbed because the clear wins
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_pending
        assign pending_d[gi] = (pending_q[gi] | req_vec[gi]) & ~grant_clr[gi];
    end

    // Cut-in condition: something strictly outranking the current grant waits
    always_comb begin
        preempt = 1'b0;
`ifdef SOUND_PREEMPT_EN
        preempt = (state_q == PLAY) && (|(pending_q & higher_mask(grant_q)));
`else
        preempt = 1'b0;
`endif
    end

    // FSM next-state, counter reload/count-down and divider control
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        grant_clr = '0;
        div_load  = 1'b0;
        div_clear = 1'b0;
        div_en    = 1'b0;
        div_half  = half_of(pick);
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    state_d   = PLAY;
                    grant_d   = pick;
                    grant_clr = pick;
                    cnt_d     = dur_of(pick);
                    div_load  = 1'b1;
                    div_clear = 1'b1;
                end
            end
            PLAY: begin
                if (preempt) begin
                    grant_d   = pick;
                    grant_clr = pick;
                    cnt_d     = dur_of(pick);
                    div_load  = 1'b1;
                    div_clear = 1'b1;
                end else if (cnt_q == DUR_W'(1)) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    cnt_d     = DUR_W'(GAP_CYCLES);
                    div_clear = 1'b1;
                end else begin
                    cnt_d  = cnt_q - DUR_W'(1);
                    div_en = 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == DUR_W'(1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - DUR_W'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = '0;
                cnt_d     = '0;
                div_clear = 1'b1;
            end
        endcase
        busy_d = (state_d == PLAY) || (state_d == GAP);
    end

    // Arbiter state registers; busy/grant are registered so outputs never
    // depend combinationally on the request inputs
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            cnt_q     <= cnt_d;
        end
    end

    tone_divider u_tone_divider (
        .clk_i    (clk_100MHz),
        .rst_ni   (reset_n),
        .load_i   (div_load),
        .clear_i  (div_clear),
        .enable_i (div_en),
        .half_i   (div_half),
        .tone_o   (o_speaker)
    );

    assign o_busy  = busy_q;
    assign o_grant = grant_q;

endmodule
